// File: rtl/ms_serial_mouse_scheduler.sv
// Microsoft serial-mouse side of a PS/2-to-serial converter: RTS-triggered 'M'
// identification, motion/button accumulation and 3-byte packet scheduling to a UART TX.
module ms_serial_mouse_scheduler #(
    parameter int IDENT_DELAY = 500000,
    parameter int ACC_W       = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rts,
    input  logic       ev_valid,
    input  logic [8:0] ev_dx,
    input  logic [8:0] ev_dy,
    input  logic       ev_left,
    input  logic       ev_right,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       active
);

    localparam int CNT_W = (IDENT_DELAY > 1) ? $clog2(IDENT_DELAY) : 1;
    localparam logic signed [ACC_W+1:0] ACC_LIM = (ACC_W+2)'((1 << (ACC_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] PKT_LIM = ACC_W'(127);

    typedef enum logic [2:0] {
        S_OFF, S_WAIT_ID, S_SEND_ID, S_IDLE, S_B1, S_B2, S_B3
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [1:0]               btn_q, btn_d, sent_btn_q, sent_btn_d;
    logic signed [7:0]        sx_q, sx_d, sy_q, sy_d;
    logic [7:0]               tx_data_q, tx_data_d;
    logic                     tx_valid_q, tx_valid_d, active_q, active_d;
    logic                     rts_meta_q, rts_s_q, rts_prev_q;

    logic                     hs, pending, take_snap, rts_rise;
    logic signed [7:0]        snap_x, snap_y;
    logic signed [8:0]        ev_x, ev_y;
    logic signed [ACC_W+1:0]  sum_x, sum_y;

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W+1:0] v);
        if (v > ACC_LIM)       return ACC_LIM[ACC_W-1:0];
        else if (v < -ACC_LIM) return -ACC_LIM[ACC_W-1:0];
        else                   return v[ACC_W-1:0];
    endfunction

    function automatic logic signed [7:0] clamp8(input logic signed [ACC_W-1:0] v);
        if (v > PKT_LIM)       return 8'sh7F;
        else if (v < -PKT_LIM) return 8'sh81;
        else                   return v[7:0];
    endfunction

    function automatic logic [7:0] byte1(input logic [1:0] b, input logic [7:0] x, input logic [7:0] y);
        return {2'b01, b[1], b[0], y[7:6], x[7:6]};
    endfunction

    // Sync flops reset high so an RTS already asserted at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rts_meta_q <= 1'b1;
            rts_s_q    <= 1'b1;
            rts_prev_q <= 1'b1;
        end else begin
            rts_meta_q <= rts;
            rts_s_q    <= rts_meta_q;
            rts_prev_q <= rts_s_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_OFF;
            cnt_q      <= '0;
            acc_x_q    <= '0;
            acc_y_q    <= '0;
            btn_q      <= 2'b00;
            sent_btn_q <= 2'b00;
            sx_q       <= 8'sh00;
            sy_q       <= 8'sh00;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_x_q    <= acc_x_d;
            acc_y_q    <= acc_y_d;
            btn_q      <= btn_d;
            sent_btn_q <= sent_btn_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            active_q   <= active_d;
        end
    end

    // Next-state, handshake sequencing, snapshot and saturating accumulation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_x_d    = acc_x_q;
        acc_y_d    = acc_y_q;
        btn_d      = btn_q;
        sent_btn_d = sent_btn_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        active_d   = active_q;
        take_snap  = 1'b0;
        snap_x     = 8'sh00;
        snap_y     = 8'sh00;
        rts_rise   = rts_s_q & ~rts_prev_q;
        hs         = tx_valid_q & tx_ready;
        pending    = (acc_x_q != '0) || (acc_y_q != '0) || (btn_q != sent_btn_q);
        ev_x       = ev_valid ? $signed(ev_dx) : 9'sd0;
        ev_y       = ev_valid ? $signed(ev_dy) : 9'sd0;

        case (state_q)
            S_OFF: begin
                if (rts_rise) begin
                    state_d = S_WAIT_ID;
                    cnt_d   = CNT_W'(IDENT_DELAY - 1);
                end else begin
                    state_d = S_OFF;
                end
            end
            S_WAIT_ID: begin
                if (cnt_q == '0) begin
                    state_d    = S_SEND_ID;
                    tx_data_d  = 8'h4D;
                    tx_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SEND_ID: begin
                if (hs) begin
                    state_d    = S_IDLE;
                    tx_valid_d = 1'b0;
                    active_d   = 1'b1;
                end else begin
                    state_d = S_SEND_ID;
                end
            end
            S_IDLE: begin
                take_snap = pending;
            end
            S_B1: begin
                if (hs) begin
                    state_d   = S_B2;
                    tx_data_d = {2'b00, sx_q[5:0]};
                end else begin
                    state_d = S_B1;
                end
            end
            S_B2: begin
                if (hs) begin
                    state_d   = S_B3;
                    tx_data_d = {2'b00, sy_q[5:0]};
                end else begin
                    state_d = S_B2;
                end
            end
            S_B3: begin
                if (hs) begin
                    take_snap  = pending;
                    state_d    = S_IDLE;
                    tx_valid_d = 1'b0;
                end else begin
                    state_d = S_B3;
                end
            end
            default: begin
                state_d    = S_OFF;
                tx_valid_d = 1'b0;
                active_d   = 1'b0;
            end
        endcase

        if (take_snap) begin
            snap_x     = clamp8(acc_x_q);
            snap_y     = clamp8(acc_y_q);
            sx_d       = snap_x;
            sy_d       = snap_y;
            sent_btn_d = btn_q;
            state_d    = S_B1;
            tx_data_d  = byte1(btn_q, snap_x, snap_y);
            tx_valid_d = 1'b1;
        end else begin
            sent_btn_d = sent_btn_q;
        end

        // Microsoft Y is down-positive, so PS/2 dy is subtracted.
        sum_x = (ACC_W+2)'(acc_x_q) - (ACC_W+2)'(snap_x) + (ACC_W+2)'(ev_x);
        sum_y = (ACC_W+2)'(acc_y_q) - (ACC_W+2)'(snap_y) - (ACC_W+2)'(ev_y);
        if (state_q != S_OFF) begin
            acc_x_d = sat_acc(sum_x);
            acc_y_d = sat_acc(sum_y);
            btn_d   = ev_valid ? {ev_left, ev_right} : btn_q;
        end else begin
            btn_d = btn_q;
        end

        if (!rts_s_q) begin
            state_d    = S_OFF;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
            active_d   = 1'b0;
            acc_x_d    = '0;
            acc_y_d    = '0;
            btn_d      = 2'b00;
            sent_btn_d = 2'b00;
        end else begin
            active_d = active_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign active   = active_q;

endmodule
